// File: rtl/btb_pkg.sv
// Shared types, constants and helpers for the branch target buffer.
package btb_pkg;

   // Counter value given to a freshly allocated entry (weakly taken).
   localparam logic [1:0] CNT_WEAK_TAKEN_2 = 2'b10;
   localparam logic [0:0] CNT_WEAK_TAKEN_1 = 1'b1;

   // Performance counter word; wraps modulo 2^32.
   typedef logic [31:0] btb_stat_t;

   // Saturating step of a direction counter of the given width (1..8 bits).
   function automatic logic [7:0] sat_next(input logic [7:0] cnt,
                                           input logic taken,
                                           input int unsigned width);
      logic [7:0] max_v;
      max_v = 8'((9'd1 << width) - 9'd1);
      if (taken) begin
         return (cnt == max_v) ? cnt : cnt + 8'd1;
      end else begin
         return (cnt == 8'd0) ? cnt : cnt - 8'd1;
      end
   endfunction

endpackage

// File: rtl/branch_prediction_if.sv
// Fetch lookup and MEM-stage update bus between the pipeline and the BTB.
interface branch_prediction_if #(
   parameter int unsigned IDX_W = 3
);
   // fetch-side lookup
   logic [31:0]      lookup_pc;
   logic             predict;
   logic [31:0]      br_target_O;
   logic [IDX_W-1:0] index_O;
   // MEM-side resolution update
   logic             upd_en;
   logic             upd_pen;
   logic [IDX_W-1:0] upd_index;
   logic [31:0]      upd_pc;
   logic             upd_taken;
   logic [31:0]      upd_target;
   logic             upd_mispredict;

   // Pipeline side: issues lookups and resolved-branch updates.
   modport master (
      output lookup_pc, upd_en, upd_pen, upd_index, upd_pc,
             upd_taken, upd_target, upd_mispredict,
      input  predict, br_target_O, index_O
   );

   // Predictor side.
   modport slave (
      input  lookup_pc, upd_en, upd_pen, upd_index, upd_pc,
             upd_taken, upd_target, upd_mispredict,
      output predict, br_target_O, index_O
   );
endinterface

// File: rtl/btb_sat_counter.sv
// Per-entry direction counter: load has priority, otherwise saturating inc/dec.
module btb_sat_counter
   import btb_pkg::*;
#(
   parameter int unsigned CNT_W = 2
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next counter value; in 1-bit mode the saturating step equals "last outcome".
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (inc_i || dec_i) begin
         cnt_d = CNT_W'(sat_next(8'(cnt_q), inc_i, CNT_W));
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter state with asynchronous clear.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/btb_predictor.sv
// Branch target buffer: combinational fetch lookup, commit-on-PC-enable update,
// wrapping branch / mispredict counters.
module btb_predictor
   import btb_pkg::*;
#(
   parameter int unsigned ENTRIES = 8,
   parameter int unsigned TAG_W   = 8,
   parameter int unsigned CNT_W   = 2
) (
   input  logic                CLK,
   input  logic                nRST,
   branch_prediction_if.slave  bp,
   output btb_stat_t           br_count,
   output btb_stat_t           miss_count
);

   localparam int unsigned IDX_W  = $clog2(ENTRIES);
   // An untagged build still keeps a 1-bit tag that is always 0, so every
   // valid entry matches and the BTB behaves as index-only.
   localparam int unsigned TAG_SW = (TAG_W > 0) ? TAG_W : 1;
   localparam logic [CNT_W-1:0] CNT_WEAK = (CNT_W == 1) ? CNT_W'(CNT_WEAK_TAKEN_1)
                                                        : CNT_W'(CNT_WEAK_TAKEN_2);

   function automatic logic [IDX_W-1:0] index_of(input logic [31:0] pc);
      return IDX_W'(pc >> 2);
   endfunction

   function automatic logic [TAG_SW-1:0] tag_of(input logic [31:0] pc);
      if (TAG_W == 0) begin
         return '0;
      end else begin
         return TAG_SW'(pc >> (IDX_W + 2));
      end
   endfunction

   logic              valid_q  [ENTRIES];
   logic [TAG_SW-1:0] tag_q    [ENTRIES];
   logic [31:0]       target_q [ENTRIES];
   logic [CNT_W-1:0]  cnt_s    [ENTRIES];
   btb_stat_t         br_count_q;
   btb_stat_t         miss_count_q;

   logic              commit_s;
   logic              upd_hit_s;
   logic [IDX_W-1:0]  lk_idx_s;
   logic [CNT_W-1:0]  lk_cnt_s;
   logic              lk_hit_s;
   logic              predict_s;
   logic              unused_pc_s;

   // Only the index/tag field bits of the PCs matter.
   assign unused_pc_s = ^{bp.lookup_pc, bp.upd_pc};

   // Commit qualification and hit test for the resolving branch.
   always_comb begin
      commit_s  = bp.upd_en & bp.upd_pen;
      upd_hit_s = valid_q[bp.upd_index] & (tag_q[bp.upd_index] == tag_of(bp.upd_pc));
   end

   // Fetch lookup; reads pre-update state, there is no write-through bypass.
   always_comb begin
      lk_idx_s       = index_of(bp.lookup_pc);
      lk_cnt_s       = cnt_s[lk_idx_s];
      lk_hit_s       = valid_q[lk_idx_s] & (tag_q[lk_idx_s] == tag_of(bp.lookup_pc));
      predict_s      = lk_hit_s & lk_cnt_s[CNT_W-1];
      bp.predict     = predict_s;
      bp.br_target_O = predict_s ? target_q[lk_idx_s] : 32'd0;
      bp.index_O     = lk_idx_s;
   end

   // Entry valid/tag/target: a taken commit (re)writes the entry whether it hit
   // or missed; on a hit valid and tag are simply rewritten with the same values.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= 32'd0;
         end
      end else if (commit_s && bp.upd_taken) begin
         valid_q[bp.upd_index]  <= 1'b1;
         tag_q[bp.upd_index]    <= tag_of(bp.upd_pc);
         target_q[bp.upd_index] <= bp.upd_target;
      end
   end

   // Wrapping performance counters.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         br_count_q   <= 32'd0;
         miss_count_q <= 32'd0;
      end else if (commit_s) begin
         br_count_q <= br_count_q + 32'd1;
         if (bp.upd_mispredict) begin
            miss_count_q <= miss_count_q + 32'd1;
         end
      end
   end

   assign br_count   = br_count_q;
   assign miss_count = miss_count_q;

   for (genvar g = 0; g < int'(ENTRIES); g++) begin : g_cnt
      logic sel_s;
      assign sel_s = commit_s & (bp.upd_index == IDX_W'(g));

      btb_sat_counter #(.CNT_W(CNT_W)) u_cnt (
         .CLK        (CLK),
         .nRST       (nRST),
         .load_i     (sel_s & ~upd_hit_s & bp.upd_taken),
         .load_val_i (CNT_WEAK),
         .inc_i      (sel_s & upd_hit_s & bp.upd_taken),
         .dec_i      (sel_s & upd_hit_s & ~bp.upd_taken),
         .cnt_o      (cnt_s[g])
      );
   end

endmodule

// File: tb/tb_btb_predictor.sv
// Randomised self-checking bench for btb_predictor against a behavioural BTB model.
module tb_btb_predictor;
   localparam int ENTRIES = 8;
   localparam int TAG_W   = 8;
   localparam int CNT_W   = 2;
   localparam int IDX_W   = 3;

   logic        CLK = 1'b0;
   logic        nRST;
   logic [31:0] br_count;
   logic [31:0] miss_count;
   int          checks = 0;
   int          errors = 0;

   always #5 CLK = ~CLK;

   branch_prediction_if #(.IDX_W(IDX_W)) bp ();

   btb_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .bp         (bp),
      .br_count   (br_count),
      .miss_count (miss_count)
   );

   // ---------------- behavioural model ----------------
   bit          m_valid  [ENTRIES];
   int unsigned m_tag    [ENTRIES];
   logic [31:0] m_target [ENTRIES];
   int          m_cnt    [ENTRIES];
   logic [31:0] m_br;
   logic [31:0] m_miss;

   function automatic int unsigned m_index(input logic [31:0] pc);
      return (pc / 4) % ENTRIES;
   endfunction

   function automatic int unsigned m_tagf(input logic [31:0] pc);
      return (pc / (4 * ENTRIES)) % (1 << TAG_W);
   endfunction

   function automatic bit m_predict(input logic [31:0] pc);
      int unsigned i;
      i = m_index(pc);
      return m_valid[i] && (m_tag[i] == m_tagf(pc)) && (m_cnt[i] >= 2);
   endfunction

   function automatic logic [31:0] m_target_of(input logic [31:0] pc);
      return m_predict(pc) ? m_target[m_index(pc)] : 32'd0;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 1'b0; m_tag[i] = 0; m_target[i] = 32'd0; m_cnt[i] = 0;
      end
      m_br = 32'd0; m_miss = 32'd0;
   endtask

   task automatic m_commit();
      int unsigned i;
      bit hit;
      if (bp.upd_en && bp.upd_pen) begin
         i   = bp.upd_index;
         hit = m_valid[i] && (m_tag[i] == m_tagf(bp.upd_pc));
         if (hit) begin
            if (bp.upd_taken) begin
               m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
               m_target[i] = bp.upd_target;
            end else begin
               m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
            end
         end else if (bp.upd_taken) begin
            m_valid[i] = 1'b1; m_tag[i] = m_tagf(bp.upd_pc);
            m_target[i] = bp.upd_target; m_cnt[i] = 2;
         end
         m_br = m_br + 32'd1;
         if (bp.upd_mispredict) m_miss = m_miss + 32'd1;
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic en, input logic pen, input logic [31:0] upc,
                        input logic taken, input logic [31:0] tgt, input logic misp);
      bp.upd_en = en; bp.upd_pen = pen; bp.upd_pc = upc;
      bp.upd_index = IDX_W'(m_index(upc));
      bp.upd_taken = taken; bp.upd_target = tgt; bp.upd_mispredict = misp;
   endtask

   task automatic tick();
      @(posedge CLK);
      if (nRST) m_commit();
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      nRST = 1'b0; m_reset();
      bp.lookup_pc = 32'h0000_0040; drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      #3;
      checks++; if (bp.predict !== 1'b0) begin errors++; $display("FAIL reset_predict: got %0b want 0", bp.predict); end
      checks++; if (bp.br_target_O !== 32'd0) begin errors++; $display("FAIL reset_target: got %h want 0", bp.br_target_O); end
      checks++; if (bp.index_O !== 3'd0) begin errors++; $display("FAIL reset_index: got %0d want 0", bp.index_O); end
      checks++; if (br_count !== 32'd0) begin errors++; $display("FAIL reset_br_count: got %0d want 0", br_count); end
      @(posedge CLK); #1; nRST = 1'b1; #1;
      checks++; if (bp.predict !== 1'b0) begin errors++; $display("FAIL reset_release_predict: got %0b want 0", bp.predict); end
      tick();
   endtask

   task automatic test_install();
      bp.lookup_pc = 32'h0000_0040;
      drive(1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0100, 1'b0);
      #1;
      checks++; if (bp.predict !== 1'b0) begin errors++; $display("FAIL install_pre: got %0b want 0", bp.predict); end
      tick();
      drive(1'b0, 1'b1, 32'd0, 1'b0, 32'd0, 1'b0); #1;
      checks++; if (bp.predict !== 1'b1 || bp.br_target_O !== 32'h0000_0100) begin
         errors++; $display("FAIL install_hit: got %0b/%h want 1/00000100", bp.predict, bp.br_target_O); end
      checks++; if (br_count !== 32'd1) begin errors++; $display("FAIL install_br_count: got %0d want 1", br_count); end
   endtask

   task automatic test_saturation();
      logic seq [11];
      seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      bp.lookup_pc = 32'h0000_0040;
      foreach (seq[k]) begin
         drive(1'b1, 1'b1, 32'h0000_0040, seq[k], 32'h0000_0100, 1'b0);
         tick();
         drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0); #1;
         checks++; if (bp.predict !== m_predict(32'h40) || bp.br_target_O !== m_target_of(32'h40)) begin
            errors++; $display("FAIL saturation_step%0d: got %0b/%h want %0b/%h", k,
                               bp.predict, bp.br_target_O, m_predict(32'h40), m_target_of(32'h40)); end
      end
   endtask

   task automatic test_alias();
      bp.lookup_pc = 32'h0000_0060; #1;
      checks++; if (bp.predict !== 1'b0) begin errors++; $display("FAIL alias_lookup: got %0b want 0", bp.predict); end
      drive(1'b1, 1'b1, 32'h0000_0060, 1'b1, 32'h0000_0200, 1'b1);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0); #1;
      checks++; if (bp.predict !== 1'b1 || bp.br_target_O !== 32'h0000_0200) begin
         errors++; $display("FAIL alias_replace: got %0b/%h want 1/00000200", bp.predict, bp.br_target_O); end
      bp.lookup_pc = 32'h0000_0040; #1;
      checks++; if (bp.predict !== 1'b0) begin errors++; $display("FAIL alias_old_gone: got %0b want 0", bp.predict); end
   endtask

   task automatic test_stall();
      logic [31:0] br0;
      br0 = br_count;
      bp.lookup_pc = 32'h0000_0044;
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 1'b0, 32'h0000_0044, 1'b1, 32'h0000_0300, 1'b0);
         tick();
         checks++; if (bp.predict !== 1'b0 || br_count !== br0) begin
            errors++; $display("FAIL stall_hold%0d: got %0b/%0d want 0/%0d", c, bp.predict, br_count, br0); end
      end
      drive(1'b1, 1'b1, 32'h0000_0044, 1'b1, 32'h0000_0300, 1'b0); #1;
      checks++; if (bp.predict !== 1'b0) begin errors++; $display("FAIL stall_same_cycle: got %0b want 0", bp.predict); end
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0); #1;
      checks++; if (bp.predict !== 1'b1 || bp.br_target_O !== 32'h0000_0300 || br_count !== m_br) begin
         errors++; $display("FAIL stall_commit: got %0b/%h/%0d want 1/00000300/%0d",
                            bp.predict, bp.br_target_O, br_count, m_br); end
   endtask

   task automatic test_random();
      logic [31:0] lpc, upc;
      for (int n = 0; n < 400; n++) begin
         lpc = ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2) | ($urandom & 32'hFFFF_E003);
         upc = ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2) | ($urandom & 32'hFFFF_E003);
         bp.lookup_pc = lpc;
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), upc,
               1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
         #1;
         checks++; if (bp.predict !== m_predict(lpc) || bp.br_target_O !== m_target_of(lpc)
                       || bp.index_O !== IDX_W'(m_index(lpc))) begin
            errors++; $display("FAIL random_lookup%0d pc=%h: got %0b/%h/%0d want %0b/%h/%0d", n, lpc,
                               bp.predict, bp.br_target_O, bp.index_O, m_predict(lpc), m_target_of(lpc), m_index(lpc)); end
         tick();
         checks++; if (br_count !== m_br || miss_count !== m_miss) begin
            errors++; $display("FAIL random_counts%0d: got %0d/%0d want %0d/%0d", n, br_count, miss_count, m_br, m_miss); end
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 1'b1, 32'h0000_0050, 1'b1, 32'h0000_0500, 1'b1);
      bp.lookup_pc = 32'h0000_0050;
      #2; nRST = 1'b0; m_reset(); #1;
      checks++; if (bp.predict !== 1'b0 || bp.br_target_O !== 32'd0 || br_count !== 32'd0 || miss_count !== 32'd0) begin
         errors++; $display("FAIL midreset_clear: got %0b/%h/%0d/%0d want 0/0/0/0", bp.predict, bp.br_target_O, br_count, miss_count); end
      tick();
      checks++; if (bp.predict !== 1'b0 || miss_count !== 32'd0) begin
         errors++; $display("FAIL midreset_hold: got %0b/%0d want 0/0", bp.predict, miss_count); end
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      nRST = 1'b1; #1;
      checks++; if (bp.predict !== 1'b0 || bp.br_target_O !== 32'd0) begin
         errors++; $display("FAIL midreset_discard: got %0b/%h want 0/0", bp.predict, bp.br_target_O); end
      tick();
   endtask

   task automatic test_wrap();
      force dut.br_count_q = 32'hFFFF_FFFF;
      force dut.miss_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.br_count_q;
      release dut.miss_count_q;
      m_br = 32'hFFFF_FFFF; m_miss = 32'hFFFF_FFFF;
      drive(1'b1, 1'b1, 32'h0000_0058, 1'b0, 32'd0, 1'b1);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      checks++; if (br_count !== m_br || br_count !== 32'd0) begin
         errors++; $display("FAIL wrap_br_count: got %h want 00000000", br_count); end
      checks++; if (miss_count !== m_miss || miss_count !== 32'd0) begin
         errors++; $display("FAIL wrap_miss_count: got %h want 00000000", miss_count); end
   endtask

   initial begin
      test_reset();
      test_install();
      test_saturation();
      test_alias();
      test_stall();
      test_random();
      test_reset_mid();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
